// File: rtl/montgomery_pkg.sv
// Shared types and constants for the radix-2 Montgomery multiplier.
// Imported by the step datapath and the top-level controller.
package montgomery_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOOP,
      SUB,
      DONE
   } state_t;

   // Accumulator headroom: C + b + m stays below 4m.
   localparam int ACC_EXTRA = 2;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/montgomery_radix2_param_step.sv
// One radix-2 Montgomery iteration: C_next = (C + ai*b + q*m) / 2.
// q is chosen so that the sum is even and the shift is exact.
module mont_step
   import montgomery_pkg::*;
#(
   parameter int WIDTH = 1024
) (
   input  logic [WIDTH+ACC_EXTRA-1:0] c,
   input  logic [WIDTH-1:0]           b,
   input  logic [WIDTH-1:0]           m,
   input  logic                       ai,
   output logic [WIDTH+ACC_EXTRA-1:0] c_next
);

   localparam int AW = WIDTH + ACC_EXTRA;

   logic          q;
   logic [AW:0]   s1;
   logic [AW:0]   s2;

   // Parity select, two conditional additions and the exact halving.
   always_comb begin
      q      = c[0] ^ (ai & b[0]);
      s1     = {1'b0, c} + (ai ? {3'b000, b} : '0);
      s2     = s1 + (q ? {3'b000, m} : '0);
      c_next = AW'(s2 >> 1);
   end

endmodule

// File: rtl/montgomery_radix2_param.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Operands latched on start; even modulus short-circuits to an error.
module montgomery_radix2_param
   import montgomery_pkg::*;
#(
   parameter int WIDTH = 1024,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int AW = WIDTH + ACC_EXTRA;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] m_q;
   logic [AW-1:0]    acc;
   logic [AW-1:0]    acc_nx;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             sub_ok;
   logic [WIDTH-1:0] diff;

   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign sub_ok = (acc >= {2'b00, m_q});
   assign diff   = acc[WIDTH-1:0] - m_q;

   mont_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .c      (acc),
      .b      (b_q),
      .m      (m_q),
      .ai     (a_q[cnt]),
      .c_next (acc_nx)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state: odd modulus runs the loop, even modulus reports at once.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = in_m[0] ? LOOP : DONE;
         LOOP:    if (last) state_nx = SUB;
         SUB:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      done = (state == DONE);
      busy = (state == LOOP) || (state == SUB);
   end

   // Operand latch, accumulator iteration and final conditional subtract.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q <= in_a;
                  b_q <= in_b;
                  m_q <= in_m;
                  acc <= '0;
                  cnt <= '0;
                  err <= ~in_m[0];
                  if (!in_m[0]) result <= '0;
               end
            end
            LOOP: begin
               acc <= acc_nx;
               cnt <= cnt + CNT_W'(1);
            end
            SUB: begin
               result <= sub_ok ? diff : acc[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_radix2_param.sv
// Scoreboard bench: stimulus queues expected responses, a monitor
// pops and checks them on every done pulse (WIDTH=8 and WIDTH=13).
module tb_montgomery_radix2_param;

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          done_cyc;
      int          busy_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;

   logic        start0 = 1'b0;
   logic [7:0]  a0 = '0, b0 = '0, m0 = '0;
   logic [7:0]  r0;
   logic        d0, bz0, e0;

   logic        start1 = 1'b0;
   logic [12:0] a1 = '0, b1 = '0, m1 = '0;
   logic [12:0] r1;
   logic        d1, bz1, e1;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   bc0 = 0, bc1 = 0;
   exp_t q0[$];
   exp_t q1[$];

   montgomery_radix2_param #(.WIDTH(8)) dut8 (
      .clk    (clk),
      .resetn (resetn),
      .start  (start0),
      .in_a   (a0),
      .in_b   (b0),
      .in_m   (m0),
      .result (r0),
      .done   (d0),
      .busy   (bz0),
      .err    (e0)
   );

   montgomery_radix2_param #(.WIDTH(13)) dut13 (
      .clk    (clk),
      .resetn (resetn),
      .start  (start1),
      .in_a   (a1),
      .in_b   (b1),
      .in_m   (m1),
      .result (r1),
      .done   (d1),
      .busy   (bz1),
      .err    (e1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop one expectation per done pulse and compare.
   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         bc0 = 0;
         bc1 = 0;
      end else begin
         if (d0) begin
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL w8 unexpected done at cycle %0d", cyc);
            end else begin
               e = q0.pop_front();
               chk("w8 result", int'(r0), int'(e.res));
               chk("w8 err", int'(e0), int'(e.err));
               chk("w8 latency", cyc, e.done_cyc);
               chk("w8 busy cycles", bc0, e.busy_n);
               chk("w8 busy with done", int'(bz0), 0);
            end
            bc0 = 0;
         end else if (bz0) begin
            bc0++;
         end
         if (d1) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL w13 unexpected done at cycle %0d", cyc);
            end else begin
               e = q1.pop_front();
               chk("w13 result", int'(r1), int'(e.res));
               chk("w13 err", int'(e1), int'(e.err));
               chk("w13 latency", cyc, e.done_cyc);
               chk("w13 busy cycles", bc1, e.busy_n);
            end
            bc1 = 0;
         end else if (bz1) begin
            bc1++;
         end
      end
   end

   // Issue one WIDTH=8 operation; called and returns on a negedge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] m, input logic [7:0] res,
                      input logic er);
      exp_t e;
      e.res      = {8'h00, res};
      e.err      = er;
      e.done_cyc = cyc + (m[0] ? 10 : 1);
      e.busy_n   = m[0] ? 9 : 0;
      q0.push_back(e);
      a0 = a;
      b0 = b;
      m0 = m;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic op13(input logic [12:0] a, input logic [12:0] b,
                       input logic [12:0] m, input logic [12:0] res);
      exp_t e;
      e.res      = {3'b000, res};
      e.err      = 1'b0;
      e.done_cyc = cyc + 15;
      e.busy_n   = 14;
      q1.push_back(e);
      a1 = a;
      b1 = b;
      m1 = m;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic wait8();
      int n = 0;
      while (!d0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!d0) begin
         checks++;
         errors++;
         $display("FAIL w8 timeout: done not seen after %0d cycles", n);
      end
   endtask

   task automatic wait13();
      int n = 0;
      while (!d1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!d1) begin
         checks++;
         errors++;
         $display("FAIL w13 timeout: done not seen after %0d cycles", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset result", int'(r0), 0);
      chk("reset done", int'(d0), 0);
      chk("reset busy", int'(bz0), 0);
      chk("reset err", int'(e0), 0);
      resetn = 1'b1;
      @(negedge clk);

      // Case 1: 5*7*R^-1 mod 13 = 1
      op8(8'h05, 8'h07, 8'h0D, 8'h01, 1'b0);
      wait8();
      repeat (3) @(negedge clk);
      chk("w8 result held", int'(r0), 1);

      // Case 2: 12*12 -> 3, then back-to-back 0*11 -> 0
      op8(8'h0C, 8'h0C, 8'h0D, 8'h03, 1'b0);
      wait8();
      @(negedge clk);
      op8(8'h00, 8'h0B, 8'h0D, 8'h00, 1'b0);
      wait8();
      @(negedge clk);

      // Case 3: even modulus reports err, then a valid start clears it
      op8(8'h33, 8'h44, 8'h0C, 8'h00, 1'b1);
      wait8();
      repeat (3) @(negedge clk);
      chk("w8 err held", int'(e0), 1);
      chk("w8 err result zero", int'(r0), 0);
      op8(8'h05, 8'h07, 8'h0D, 8'h01, 1'b0);
      chk("w8 err cleared", int'(e0), 0);
      wait8();
      @(negedge clk);

      // Case 4: start and operands toggled during LOOP are ignored
      op8(8'h05, 8'h07, 8'h0D, 8'h01, 1'b0);
      for (int i = 0; i < 3; i++) begin
         start0 = 1'b1;
         a0 = 8'($urandom);
         b0 = 8'($urandom);
         m0 = 8'($urandom) | 8'h01;
         @(negedge clk);
      end
      start0 = 1'b0;
      wait8();
      @(negedge clk);

      // Case 5: asynchronous reset in the middle of LOOP
      op8(8'h05, 8'h07, 8'h0D, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async reset result", int'(r0), 0);
      chk("async reset busy", int'(bz0), 0);
      chk("async reset done", int'(d0), 0);
      chk("async reset err", int'(e0), 0);
      q0.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      op8(8'h05, 8'h07, 8'h0D, 8'h01, 1'b0);
      wait8();
      @(negedge clk);

      // WIDTH=13: non power-of-two iteration count
      op13(13'd5, 13'd7, 13'd13, 13'd11);
      wait13();
      @(negedge clk);
      op13(13'd1000, 13'd3000, 13'd8191, 13'd2094);
      wait13();
      @(negedge clk);
      op13(13'd8190, 13'd8190, 13'd8191, 13'd1);
      wait13();
      @(negedge clk);
      op13(13'd12, 13'd12, 13'd13, 13'd7);
      wait13();

      repeat (4) @(negedge clk);
      chk("w8 scoreboard drained", q0.size(), 0);
      chk("w13 scoreboard drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/montgomery_radix2_param.md
Name: montgomery_radix2_param

Overview:
Parametrised bit-serial Montgomery modular multiplier, the generalised successor of the fixed 1024-bit multiplier in the modular-exponentiation datapath.
- Computes result = a*b*R^-1 mod m, with R = 2^WIDTH.
- Operand width is set at elaboration.
- Adds a busy flag and an even-modulus error path.
- Latches operands once and holds the result until the next completed operation.

Parameters:
WIDTH, 1024, operand/modulus/result width in bits (>= 4).
CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
in_a  input  WIDTH  multiplicand, requires in_a < in_m
in_b  input  WIDTH  multiplier, requires in_b < in_m
in_m  input  WIDTH  modulus, must be odd
result  output  WIDTH  Montgomery product, valid when done=1, held afterwards
done  output  1  one-cycle completion pulse
busy  output  1  high from the cycle after accepted start until done
err  output  1  high with done when in_m was even; held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset, including mid-operation: state=IDLE; result=0, done=0, busy=0, err=0; accumulator C=0; counter=0.
- FSM states: IDLE, LOOP, SUB, DONE.
- IDLE, start=1 at edge T0:
  - latch a, b, m into internal registers; C<=0; cnt<=0; err<=0.
  - if m[0]=0: go to DONE with err<=1 and result<=0.
  - otherwise: go to LOOP.
- LOOP, one bit per cycle, LSB first:
  - ai = a[cnt]; q = C[0] ^ (ai & b[0]).
  - C <= (C + ai*b + q*m) >> 1.
  - C is WIDTH+2 bits wide, because C + b + m < 4m.
  - cnt increments each cycle; after the cycle with cnt=WIDTH-1, go to SUB.
- SUB (one cycle): D = C - m at WIDTH+2 bits. If D is non-negative, result<=D[WIDTH-1:0], else result<=C[WIDTH-1:0]. Go to DONE.
- DONE (one cycle): done=1, busy=0. Next state IDLE.
- Latency:
  - odd m: done high in the cycle after edge T0+WIDTH+2, i.e. WIDTH+2 cycles from the start edge (10 for WIDTH=8).
  - even m: done high after edge T0+1.
- busy=1 in LOOP and SUB.
- start is ignored in LOOP, SUB and DONE. No queuing.
- Inputs are not required to be stable after the start edge, since operands are latched.
- result and err hold their values after done until the next accepted start (err clears on start).
- Operands with a >= m or b >= m: no checking. The output is still < m after the single subtraction only when a, b < m. Outside that range behaviour is unspecified but must not hang: done always fires.
- WIDTH not a power of two: the counter terminates at WIDTH-1 exactly.

Decomposition:
- Package montgomery_pkg holds:
  - the state enum (IDLE, LOOP, SUB, DONE);
  - a localparam function for CNT_W;
  - the constant ACC_EXTRA = 2 for accumulator headroom.
- One combinational sub-module, mont_step: inputs C, b, m, ai; output C_next. It contains the parity q, the two additions and the shift. It is parametrised by WIDTH and unit-testable alone.
- FSM, counter, operand registers and final subtraction stay in the top module.

Test Plan:
1. WIDTH=8, m=0x0D, a=0x05, b=0x07, start pulse -> done after 10 cycles, result=0x01, err=0, busy high for the 9 cycles before done.
2. WIDTH=8, m=0x0D, a=0x0C, b=0x0C -> result=0x03. Then a=0x00, b=0x0B issued back-to-back on the cycle after done -> result=0x00.
3. WIDTH=8, m=0x0C (even), any a/b -> done one cycle after start, err=1, result=0x00, busy never asserted. Next valid start clears err.
4. WIDTH=8, start re-asserted and in_a/in_b/in_m changed to random values during LOOP -> ignored. Result still 0x01 for the case-1 operands.
5. WIDTH=8, resetn pulled low at LOOP cycle 4 of case 1 -> all outputs 0 immediately (asynchronous). A fresh start after release gives result=0x01 with full latency.
6. WIDTH=1024, the standard 1024-bit vector from the test vector generator script plus 100 random odd-m vectors -> result matches the Python golden model, latency 1026 cycles each.
